// File: rtl/tetris_pkg.sv
// Shared board geometry and FSM encoding for the tetris
// line-clear datapath.
package tetris_pkg;

   localparam int TILES_PER_ROW = 10;
   localparam int ROWS          = 20;
   localparam int P2_BASE       = 200;
   localparam int TILE_W        = 4;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CHECK,
      WRITE,
      FILL,
      DONE
   } lc_state_e;

endpackage

// File: rtl/line_row_buffer.sv
// One board row of tile codes, filled column by column, with a
// full flag that already reflects the write presented this cycle.
module line_row_buffer #(
   parameter int TILES_PER_ROW = tetris_pkg::TILES_PER_ROW,
   parameter int TILE_W        = tetris_pkg::TILE_W,
   localparam int CW           = $clog2(TILES_PER_ROW)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              we,
   input  logic [CW-1:0]     wcol,
   input  logic [TILE_W-1:0] wdata,
   input  logic [CW-1:0]     rcol,
   output logic [TILE_W-1:0] rdata,
   output logic              full
);

   logic [TILE_W-1:0] tiles_q [TILES_PER_ROW];
   logic [TILE_W-1:0] tiles_d [TILES_PER_ROW];

   always_comb begin
      tiles_d = tiles_q;
      if (we) begin
         tiles_d[wcol] = wdata;
      end
   end

   // Looking at tiles_d lets the last column count in its capture cycle.
   always_comb begin
      full = 1'b1;
      for (int i = 0; i < TILES_PER_ROW; i++) begin
         if (tiles_d[i] == '0) begin
            full = 1'b0;
         end
      end
   end

   assign rdata = tiles_q[rcol];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < TILES_PER_ROW; i++) begin
            tiles_q[i] <= '0;
         end
      end else begin
         tiles_q <= tiles_d;
      end
   end

endmodule

// File: rtl/line_clear_engine.sv
// Scans a board bottom-up over Avalon-MM, compacts non-full rows
// downward and zero-fills the rows vacated at the top.
module line_clear_engine #(
   parameter int TILES_PER_ROW = tetris_pkg::TILES_PER_ROW,
   parameter int ROWS          = tetris_pkg::ROWS,
   parameter int P2_BASE       = tetris_pkg::P2_BASE
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        start,
   input  logic        player,
   output logic        busy,
   output logic        done,
   output logic [4:0]  lines_cleared,
   output logic        avm_read,
   output logic        avm_write,
   output logic [11:0] avm_address,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata
);

   import tetris_pkg::*;

   localparam int CW = $clog2(TILES_PER_ROW);
   localparam int RW = $clog2(ROWS);
   localparam logic [CW-1:0] LAST_COL = CW'(TILES_PER_ROW - 1);
   localparam logic [RW-1:0] TOP_ROW  = RW'(ROWS - 1);

   lc_state_e state_q, state_d;
   logic player_q, player_d;
   logic [RW-1:0] src_q, src_d;
   // Extra MSB marks dst having stepped past row 0.
   logic [RW:0] dst_q, dst_d;
   logic [CW-1:0] col_q, col_d;
   logic [4:0] cnt_q, cnt_d;
   logic [4:0] lines_q, lines_d;

   logic buf_we;
   logic [CW-1:0] buf_wcol;
   logic [TILE_W-1:0] buf_rdata;
   logic row_full;
   logic adv;
   logic [RW-1:0] row_sel;
   logic [11:0] base;
   logic [11:0] addr;
   logic unused_rd;

   assign unused_rd = ^avm_readdata[31:TILE_W];

   line_row_buffer #(
      .TILES_PER_ROW (TILES_PER_ROW),
      .TILE_W        (TILE_W)
   ) u_buf (
      .CLK   (CLK),
      .RESET (RESET),
      .we    (buf_we),
      .wcol  (buf_wcol),
      .wdata (avm_readdata[TILE_W-1:0]),
      .rcol  (col_q),
      .rdata (buf_rdata),
      .full  (row_full)
   );

   assign row_sel = (state_q == READ) ? src_q : dst_q[RW-1:0];
   assign base    = player_q ? 12'(P2_BASE) : 12'd0;
   assign addr    = base
                  + 12'(row_sel) * 12'(TILES_PER_ROW)
                  + 12'(col_q);

   assign busy           = (state_q != IDLE);
   assign lines_cleared  = lines_q;
   assign avm_byteenable = 4'hF;

   always_comb begin
      state_d       = state_q;
      player_d      = player_q;
      src_d         = src_q;
      dst_d         = dst_q;
      col_d         = col_q;
      cnt_d         = cnt_q;
      lines_d       = lines_q;
      buf_we        = 1'b0;
      buf_wcol      = LAST_COL;
      adv           = 1'b0;
      done          = 1'b0;
      avm_read      = 1'b0;
      avm_write     = 1'b0;
      avm_address   = '0;
      avm_writedata = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               player_d = player;
               src_d    = TOP_ROW;
               dst_d    = {1'b0, TOP_ROW};
               cnt_d    = '0;
               col_d    = '0;
               state_d  = READ;
            end
         end
         READ: begin
            avm_read    = 1'b1;
            avm_address = addr;
            // Data for the previous column returns this cycle.
            buf_we      = (col_q != '0);
            buf_wcol    = col_q - CW'(1);
            if (col_q == LAST_COL) begin
               col_d   = '0;
               state_d = CHECK;
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         CHECK: begin
            buf_we   = 1'b1;
            buf_wcol = LAST_COL;
            if (row_full) begin
               cnt_d = cnt_q + 5'd1;
               adv   = 1'b1;
            end else if (dst_q != {1'b0, src_q}) begin
               col_d   = '0;
               state_d = WRITE;
            end else begin
               dst_d = dst_q - (RW+1)'(1);
               adv   = 1'b1;
            end
         end
         WRITE: begin
            avm_write     = 1'b1;
            avm_address   = addr;
            avm_writedata = 32'(buf_rdata);
            if (col_q == LAST_COL) begin
               col_d = '0;
               dst_d = dst_q - (RW+1)'(1);
               adv   = 1'b1;
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         FILL: begin
            avm_write   = 1'b1;
            avm_address = addr;
            if (col_q == LAST_COL) begin
               col_d = '0;
               if (dst_q[RW-1:0] == '0) begin
                  state_d = DONE;
               end else begin
                  dst_d = dst_q - (RW+1)'(1);
               end
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         DONE: begin
            done    = 1'b1;
            lines_d = cnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Row finished: either climb to the next source row or wrap up.
      if (adv) begin
         if (src_q == '0) begin
            state_d = dst_d[RW] ? DONE : FILL;
         end else begin
            src_d   = src_q - RW'(1);
            state_d = READ;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         player_q <= 1'b0;
         src_q    <= '0;
         dst_q    <= '0;
         col_q    <= '0;
         cnt_q    <= '0;
         lines_q  <= '0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         col_q    <= col_d;
         cnt_q    <= cnt_d;
         lines_q  <= lines_d;
      end
   end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed and randomized passes of line_clear_engine against a
// tile-RAM slave and a row-compaction reference model.
module tb_line_clear_engine;

   localparam int TPR   = 10;
   localparam int NR    = 20;
   localparam int P2    = 200;
   localparam int WORDS = 400;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        player;
   logic        busy;
   logic        done;
   logic [4:0]  lines;
   logic        avm_read;
   logic        avm_write;
   logic [11:0] avm_address;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;

   logic [31:0] mem     [0:4095];
   logic [31:0] img     [0:WORDS-1];
   logic [31:0] exp_mem [0:WORDS-1];
   logic        load;

   int checks   = 0;
   int failures = 0;
   int busy_tot = 0;
   int done_tot = 0;
   int wr_tot   = 0;
   int both_tot = 0;
   int be_bad   = 0;

   always #10 clk = ~clk;

   line_clear_engine dut (
      .CLK            (clk),
      .RESET          (rst_n),
      .start          (start),
      .player         (player),
      .busy           (busy),
      .done           (done),
      .lines_cleared  (lines),
      .avm_read       (avm_read),
      .avm_write      (avm_write),
      .avm_address    (avm_address),
      .avm_writedata  (avm_writedata),
      .avm_byteenable (avm_byteenable),
      .avm_readdata   (avm_readdata)
   );

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < WORDS; i++) begin
            mem[i] <= img[i];
         end
      end else if (avm_write) begin
         mem[avm_address] <= avm_writedata;
         wr_tot <= wr_tot + 1;
         if (avm_byteenable != 4'hF) be_bad <= be_bad + 1;
      end
      avm_readdata <= mem[avm_address];
      if (avm_read && avm_write) both_tot <= both_tot + 1;
   end

   always @(negedge clk) begin
      if (busy) busy_tot <= busy_tot + 1;
      if (done) done_tot <= done_tot + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp_v);
      end
   endtask

   task automatic load_img();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic img_clear();
      for (int i = 0; i < WORDS; i++) img[i] = 32'd0;
   endtask

   // Surviving rows keep their bottom-up order, packed against row NR-1.
   function automatic void build_exp(input int base,
                                     output int cnt,
                                     output int moved);
      int kept[$];
      bit full;
      for (int i = 0; i < WORDS; i++) exp_mem[i] = img[i];
      for (int r = NR - 1; r >= 0; r--) begin
         full = 1'b1;
         for (int c = 0; c < TPR; c++) begin
            if (img[base + r*TPR + c][3:0] == 4'd0) full = 1'b0;
         end
         if (!full) kept.push_back(r);
      end
      cnt   = NR - kept.size();
      moved = 0;
      for (int k = 0; k < NR; k++) begin
         int r;
         r = NR - 1 - k;
         if (k < kept.size()) begin
            if (kept[k] != r) begin
               moved++;
               for (int c = 0; c < TPR; c++) begin
                  exp_mem[base + r*TPR + c] =
                     {28'd0, img[base + kept[k]*TPR + c][3:0]};
               end
            end
         end else begin
            for (int c = 0; c < TPR; c++) begin
               exp_mem[base + r*TPR + c] = 32'd0;
            end
         end
      end
   endfunction

   task automatic run_pass(input logic plyr,
                           input int restart_at,
                           input int exp_lines,
                           input int exp_busy,
                           input int exp_wr);
      int b0, d0, w0, n, mism;
      bit seen;
      @(negedge clk);
      b0 = busy_tot;
      d0 = done_tot;
      w0 = wr_tot;
      start  = 1'b1;
      player = plyr;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 3000) begin
         @(negedge clk);
         n++;
         if (n == restart_at) begin
            start  = 1'b1;
            player = ~plyr;
         end else begin
            start  = 1'b0;
            player = plyr;
         end
         seen = (done_tot != d0);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pass_done_seen", 32'(seen), 32'd1);
      chk("done_pulses", done_tot - d0, 1);
      chk("busy_cycles", busy_tot - b0, exp_busy);
      chk("write_count", wr_tot - w0, exp_wr);
      chk("lines_cleared", 32'(lines), exp_lines);
      repeat (5) @(negedge clk);
      chk("lines_hold", 32'(lines), exp_lines);
      mism = 0;
      for (int i = 0; i < WORDS; i++) begin
         if (mem[i] !== exp_mem[i]) mism++;
      end
      chk("board_words_wrong", mism, 0);
   endtask

   task automatic img_random();
      logic [31:0] hi;
      logic [3:0]  t;
      int          mode;
      for (int r = 0; r < 2*NR; r++) begin
         mode = $urandom_range(0, 2);
         for (int c = 0; c < TPR; c++) begin
            if (mode == 0 || $urandom_range(0, 1) == 1)
               t = 4'($urandom_range(1, 15));
            else
               t = 4'd0;
            hi = $urandom();
            img[r*TPR + c] = {hi[31:4], t};
         end
      end
   endtask

   initial begin
      int  cnt, moved, n;
      logic pl;
      rst_n  = 1'b0;
      start  = 1'b0;
      player = 1'b0;
      load   = 1'b0;
      img_clear();
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_read", 32'(avm_read), 0);
      chk("rst_write", 32'(avm_write), 0);
      chk("rst_lines", 32'(lines), 0);
      chk("rst_addr", 32'(avm_address), 0);
      chk("rst_wdata", avm_writedata, 0);
      rst_n = 1'b1;

      // empty player-1 board
      build_exp(0, cnt, moved);
      load_img();
      run_pass(1'b0, 0, 0, 221, 0);

      // row 19 full, row 18 = {2,0,...}
      img_clear();
      for (int c = 0; c < TPR; c++) img[190 + c] = 32'd1;
      img[180] = 32'd2;
      build_exp(0, cnt, moved);
      load_img();
      run_pass(1'b0, 0, 1, 421, 200);
      chk("p1_r19c0", mem[190], 2);
      chk("p1_r19c1", mem[191], 0);
      chk("p1_r18c0", mem[180], 0);

      // player 2, rows 16..19 full, row 15 = {0,3,3,0,...}
      img_clear();
      for (int i = 360; i < 400; i++) img[i] = 32'd1;
      img[351] = 32'd3;
      img[352] = 32'd3;
      build_exp(P2, cnt, moved);
      load_img();
      run_pass(1'b1, 0, 4, 421, 200);
      chk("p2_390", mem[390], 0);
      chk("p2_391", mem[391], 3);
      chk("p2_392", mem[392], 3);
      chk("p2_351", mem[351], 0);

      // every player-1 tile occupied
      img_clear();
      for (int i = 0; i < 200; i++) img[i] = 32'd5;
      build_exp(0, cnt, moved);
      load_img();
      run_pass(1'b0, 0, 20, 421, 200);
      chk("all_full_w0", mem[0], 0);

      // restart pulsed during READ is ignored
      img_clear();
      for (int c = 0; c < TPR; c++) img[190 + c] = 32'd1;
      img[180] = 32'd2;
      for (int c = 0; c < TPR; c++) img[390 + c] = 32'd7;
      build_exp(0, cnt, moved);
      load_img();
      run_pass(1'b0, 4, 1, 421, 200);

      // randomized boards
      for (int t = 0; t < 6; t++) begin
         img_random();
         pl = 1'($urandom_range(0, 1));
         build_exp(pl ? P2 : 0, cnt, moved);
         load_img();
         run_pass(pl, 0, cnt,
                  NR*(TPR+1) + TPR*(moved + cnt) + 1,
                  TPR*(moved + cnt));
      end

      // reset in the middle of WRITE, lines_cleared nonzero beforehand
      img_clear();
      for (int c = 0; c < TPR; c++) img[190 + c] = 32'd1;
      img[180] = 32'd2;
      build_exp(0, cnt, moved);
      load_img();
      run_pass(1'b0, 0, 1, 421, 200);
      load_img();
      @(negedge clk);
      start  = 1'b1;
      player = 1'b0;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!avm_write && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("write_seen", 32'(avm_write), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_write", 32'(avm_write), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_lines", 32'(lines), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_addr", 32'(avm_address), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt   = done_tot;
      moved = wr_tot;
      repeat (30) @(negedge clk);
      chk("post_rst_no_done", done_tot - cnt, 0);
      chk("post_rst_no_write", wr_tot - moved, 0);
      chk("partial_r19c0", mem[190], 2);
      chk("partial_r19c9", mem[199], 1);

      chk("strobe_overlap", both_tot, 0);
      chk("byteenable_bad", be_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
